// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier built around a single 8x8 partial multiplier
// reused over four steps, with valid/ready handshakes on both sides.
module mult16_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] P,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] acc_reg;
    logic [1:0]  step_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        busy_reg;

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] partial;
    logic [31:0] partial_shifted;
    logic        zero_operand;

    // step[1] picks the A byte, step[0] picks the B byte; the shift is the sum of byte weights
    always_comb begin
        op_a            = step_reg[1] ? a_reg[15:8] : a_reg[7:0];
        op_b            = step_reg[0] ? b_reg[15:8] : b_reg[7:0];
        partial         = 16'(op_a) * 16'(op_b);
        partial_shifted = {16'h0000, partial};
        case (step_reg)
            2'd0:    partial_shifted = {16'h0000, partial};
            2'd1,
            2'd2:    partial_shifted = {8'h00, partial, 8'h00};
            default: partial_shifted = {partial, 16'h0000};
        endcase
    end

    assign zero_operand = (A == 16'h0000) || (B == 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            step_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= A;
                        b_reg        <= B;
                        acc_reg      <= '0;
                        step_reg     <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (ZERO_SKIP && zero_operand) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_reg  <= acc_reg + partial_shifted;
                    step_reg <= step_reg + 2'd1;
                    if (step_reg == 2'd3) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        // Clearing the accumulator here keeps P at zero while idle
                        state_reg     <= IDLE;
                        acc_reg       <= '0;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    acc_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign P         = acc_reg;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed and table-driven bench for mult16_seq_ctrl, with one instance per ZERO_SKIP setting.
module tb_mult16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] A;
    logic [15:0] B;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] P1;
    logic        in_ready0, out_valid0, busy0;
    logic [31:0] P0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult16_seq_ctrl #(.ZERO_SKIP(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .out_valid(out_valid1), .out_ready(out_ready),
        .P(P1), .busy(busy1)
    );

    mult16_seq_ctrl #(.ZERO_SKIP(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .A(A), .B(B), .out_valid(out_valid0), .out_ready(out_ready),
        .P(P0), .busy(busy0)
    );

    // lat1: edges after the handshake edge before out_valid shows on the ZERO_SKIP=1 unit
    // (0 means DONE straight from the handshake edge)
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        int          lat1;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge where both units are idle
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready1 && in_ready0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        bit          ok;
        int          lat1 = -1;
        int          lat0 = -1;
        logic [31:0] p1c = '0;
        logic [31:0] p0c = '0;
        wait_idle(ok);
        check($sformatf("vec%0d idle_wait", idx), 32'(ok), 32'd1);
        A = v.a;
        B = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            if (out_valid1 && lat1 < 0) begin
                lat1 = e;
                p1c  = P1;
            end
            if (out_valid0 && lat0 < 0) begin
                lat0 = e;
                p0c  = P0;
            end
            if (lat1 >= 0 && lat0 >= 0) break;
            @(negedge clk);
        end
        check($sformatf("vec%0d zs1_lat", idx), 32'(lat1), 32'(v.lat1));
        check($sformatf("vec%0d zs0_lat", idx), 32'(lat0), 32'd4);
        check($sformatf("vec%0d zs1_p", idx), p1c, v.p);
        check($sformatf("vec%0d zs0_p", idx), p0c, v.p);
        $display("txn vec%0d A=%04h B=%04h P1=%08h P0=%08h lat1=%0d lat0=%0d",
                 idx, v.a, v.b, p1c, p0c, lat1, lat0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          seen;
        int          lowcnt;
        int          ovlat;
        int          prev;
        logic [31:0] pcap;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0] = '{16'h1234, 16'h5678, 32'h06260060, 4};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4};
        vecs[2] = '{16'h0000, 16'hBEEF, 32'h00000000, 0};
        vecs[3] = '{16'h00FF, 16'h0100, 32'h0000FF00, 4};
        vecs[4] = '{16'h0003, 16'h0005, 32'h0000000F, 4};
        vecs[5] = '{16'hBEEF, 16'h0000, 32'h00000000, 0};
        vecs[6] = '{16'h8000, 16'h0002, 32'h00010000, 4};
        vecs[7] = '{16'h0001, 16'hFFFF, 32'h0000FFFF, 4};
        vecs[8] = '{16'h00FF, 16'h00FF, 32'h0000FE01, 4};
        vecs[9] = '{16'hFF00, 16'hFF00, 32'hFE010000, 4};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready1), 32'd1);
        check("reset out_valid", 32'(out_valid1), 32'd0);
        check("reset busy", 32'(busy1), 32'd0);
        check("reset P", P1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency and in_ready-low window with out_ready held high
        A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("seq1 busy", 32'(busy1), 32'd1);
        lowcnt = 0; ovlat = -1; pcap = '0;
        for (int e = 0; e <= 20; e++) begin
            if (out_valid1 && ovlat < 0) begin
                ovlat = e;
                pcap  = P1;
            end
            if (in_ready1) break;
            lowcnt++;
            @(negedge clk);
        end
        check("seq1 in_ready_low_cycles", 32'(lowcnt), 32'd5);
        check("seq1 latency", 32'(ovlat), 32'd4);
        check("seq1 P", pcap, 32'h06260060);
        $display("txn seq1 A=1234 B=5678 P=%08h lat=%0d low=%0d", pcap, ovlat, lowcnt);

        for (int i = 0; i < 10; i++) do_txn(vecs[i], i);

        // Backpressure: result held for 10 cycles while a new request waits
        wait_idle(ok);
        check("bp idle_wait", 32'(ok), 32'd1);
        out_ready = 1'b0;
        A = 16'h00FF; B = 16'h0100; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp out_valid", 32'(out_valid1), 32'd1);
        check("bp P", P1, 32'h0000FF00);
        A = 16'h0007; B = 16'h0009; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", i), 32'(out_valid1), 32'd1);
            check($sformatf("bp hold%0d P", i), P1, 32'h0000FF00);
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready1), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 32'(out_valid1), 32'd0);
        check("bp release in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        check("bp held_req accepted", 32'(busy1), 32'd1);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp held_req out_valid", 32'(out_valid1), 32'd1);
        check("bp held_req P", P1, 32'd63);
        $display("txn backpressure A=00FF B=0100 then A=7 B=9 P=%08h", P1);
        @(negedge clk);

        // Reset on the edge that completes step 2
        wait_idle(ok);
        check("rstmul idle_wait", 32'(ok), 32'd1);
        A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmul in_ready", 32'(in_ready1), 32'd1);
        check("rstmul busy", 32'(busy1), 32'd0);
        check("rstmul P", P1, 32'd0);
        check("rstmul nz in_ready", 32'(in_ready0), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid1 | out_valid0;
        end
        check("rstmul no out_valid", 32'(seen), 32'd0);

        // Request presented under reset is only taken after reset drops
        rst = 1'b1; A = 16'd3; B = 16'd5; in_valid = 1'b1;
        @(negedge clk);
        check("rstreq not accepted", 32'(busy1), 32'd0);
        check("rstreq in_ready", 32'(in_ready1), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rstreq accepted", 32'(busy1), 32'd1);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstreq out_valid", 32'(out_valid1), 32'd1);
        check("rstreq P", P1, 32'd15);
        $display("txn rstreq A=3 B=5 P=%08h", P1);
        @(negedge clk);

        // Back-to-back random non-zero operands
        in_valid = 1'b1; out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom_range(1, 65535));
            rb = 16'($urandom_range(1, 65535));
            wait_idle(ok);
            A = ra; B = rb;
            @(negedge clk);
            for (int e = 0; e < 20; e++) begin
                if (out_valid1) break;
                @(negedge clk);
            end
            check($sformatf("rnd%0d done", i), 32'(ok & out_valid1), 32'd1);
            check($sformatf("rnd%0d P", i), P1, 32'(ra) * 32'(rb));
            if (prev >= 0) check($sformatf("rnd%0d period", i), 32'(cyc - prev), 32'd6);
            $display("txn rnd%0d A=%04h B=%04h P=%08h cyc=%0d", i, ra, rb, P1, cyc);
            prev = cyc;
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
